fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: XLEN, 32, instruction width.
REQ-002 Parameter: VPC_BITS, 32, PC width.
REQ-003 Parameter: BTB_ENTRIES, 16, BTB entry count; power of two, at least 2.
REQ-004 Parameter: RESET_PC, 0, PC value after reset.
REQ-005 Ports: clk input 1 clock; rst input 1 reset, synchronous, active-high.
REQ-006 Ports: stall_D input 1, decode stall; MEM_stall input 1, memory stall.
REQ-007 Ports: EX_taken input 1, redirect/mispredict; EX_redirect_pc input VPC_BITS, correct next PC.
REQ-008 Ports: EX_is_branch input 1, resolved control-flow instruction in EX.
REQ-009 Ports: EX_pc input VPC_BITS; EX_br_taken input 1, actual outcome; EX_br_target input VPC_BITS, actual target.
REQ-010 Ports: imem_addr output VPC_BITS; imem_rdata input XLEN; imem_ready input 1, read data valid this cycle.
REQ-011 Ports: F_pc output VPC_BITS; F_inst output XLEN; F_BP_taken output 1; F_BP_target_pc output VPC_BITS; these feed the F/D register.

Function
REQ-012 The PC register SHALL drive imem_addr and F_pc combinationally; instruction memory read is combinational (zero latency).
REQ-013 Next-PC priority SHALL be: rst -> RESET_PC; EX_taken -> EX_redirect_pc, even if stalled; hold when stall_D | MEM_stall | !imem_ready; predicted taken -> BTB target; otherwise PC+4, modulo 2^VPC_BITS.
REQ-014 F_inst SHALL be imem_rdata when imem_ready=1 and EX_taken=0; otherwise F_inst SHALL be NOP (0x20000000).
REQ-015 F_BP_taken SHALL be 1 only when the BTB hits, counter>=2, imem_ready=1, and EX_taken=0.
REQ-016 F_BP_target_pc SHALL be the BTB target when F_BP_taken=1; otherwise PC+4.
REQ-017 BTB addressing: direct-mapped; index = pc[log2(BTB_ENTRIES)+1:2]; tag = remaining upper PC bits; each entry holds valid, tag, target and a 2-bit counter.
REQ-018 BTB hit SHALL mean the indexed entry is valid and its tag equals the PC tag.
REQ-019 BTB update SHALL occur when EX_is_branch=1, regardless of stalls.
REQ-020 Update on EX_pc hit: counter increments saturating at 3 if EX_br_taken, decrements saturating at 0 otherwise; target is rewritten with EX_br_target when taken.
REQ-021 Update on miss with EX_br_taken=1: allocate or replace the entry with valid=1, new tag, target EX_br_target, counter=2.
REQ-022 Update on miss with EX_br_taken=0: no change.
REQ-023 Simultaneous lookup and update of the same index SHALL see pre-update state; the write takes effect at the next posedge.

Reset
REQ-024 On rst: PC=RESET_PC and all BTB valid bits and counters = 0; F_inst=NOP and F_BP_taken=0 in the rst cycle.
REQ-025 Reset SHALL take priority over EX_taken and BTB update in the same cycle; targets and tags need no reset.

Structure
REQ-026 The NOP encoding, the 2-bit counter encodings and the default BTB_ENTRIES SHALL live in the shared pipeline package.
REQ-027 The BTB SHALL be a sub-module named btb_2bit, with a lookup port and an update port; fetch_stage holds the PC and next-PC mux.

Verification
REQ-028 Reset then run, imem_ready=1, no branches: F_pc sequence 0x0, 0x4, 0x8, 0xC; F_BP_taken=0.
REQ-029 Stall hold: stall_D=1 for 2 cycles at PC 0x10 -> PC holds at 0x10, then 0x14 one cycle after release; with MEM_stall=1, same.
REQ-030 Redirect priority: EX_taken=1, EX_redirect_pc=0x200, stall_D=1 together -> F_inst=NOP that cycle and PC=0x200 the next.
REQ-031 BTB training: EX_is_branch=1, EX_pc=0x40, EX_br_taken=1, target 0x100 -> next fetch of 0x40 gives F_BP_taken=1, F_BP_target_pc=0x100, next PC 0x100.
REQ-032 BTB training, not taken: two further not-taken updates of 0x40 -> counter=0; fetch of 0x40 gives F_BP_taken=0 and next PC 0x44.
REQ-033 I-cache miss: imem_ready=0 for 3 cycles at 0x20 -> F_inst=NOP and PC holds at 0x20.
REQ-034 Aliasing: 0x40 trained; EX_pc=0x80 (same index for 16 entries) taken, target 0x300 -> entry replaced; fetch of 0x40 misses.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: NOP encoding, branch counter states, BTB sizing.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INST            = 32'h2000_0000;
  localparam int          BTB_ENTRIES_DEFAULT = 16;

  // 2-bit saturating branch counter; the MSB is the taken prediction
  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'd0,
    CTR_WEAK_NT   = 2'd1,
    CTR_WEAK_T    = 2'd2,
    CTR_STRONG_T  = 2'd3
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      CTR_STRONG_NT: nxt = taken ? CTR_WEAK_NT  : CTR_STRONG_NT;
      CTR_WEAK_NT:   nxt = taken ? CTR_WEAK_T   : CTR_STRONG_NT;
      CTR_WEAK_T:    nxt = taken ? CTR_STRONG_T : CTR_WEAK_NT;
      CTR_STRONG_T:  nxt = taken ? CTR_STRONG_T : CTR_WEAK_T;
      default:       nxt = CTR_STRONG_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus: fetch drives the address, memory returns data and ready.
interface fetch_stage_if #(
  parameter int XLEN     = 32,
  parameter int VPC_BITS = 32
);
  logic [VPC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]     imem_rdata;
  logic                imem_ready;

  modport master (output imem_addr, input imem_rdata, input imem_ready);
  modport slave  (input imem_addr, output imem_rdata, output imem_ready);
endinterface

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
module btb_2bit
  import fetch_stage_pkg::*;
#(
  parameter int VPC_BITS    = 32,
  parameter int BTB_ENTRIES = BTB_ENTRIES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VPC_BITS-1:0] lookup_pc,
  output logic                lookup_hit,
  output logic                lookup_taken,
  output logic [VPC_BITS-1:0] lookup_target,
  input  logic                upd_en,
  input  logic [VPC_BITS-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [VPC_BITS-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = VPC_BITS - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  ctr_e                   ctr_q [BTB_ENTRIES];
  ctr_e                   ctr_d [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d [BTB_ENTRIES];
  logic [VPC_BITS-1:0]    tgt_q [BTB_ENTRIES];
  logic [VPC_BITS-1:0]    tgt_d [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[VPC_BITS-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[VPC_BITS-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not visible yet
  always_comb begin
    lookup_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lookup_taken  = lookup_hit && ctr_q[lk_idx][1];
    lookup_target = tgt_q[lk_idx];
    up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  // Entry update: train on hit, allocate on taken miss, ignore not-taken miss
  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (rst) begin
      valid_d = '0;
      for (int unsigned i = 0; i < BTB_ENTRIES; i++) ctr_d[i] = CTR_STRONG_NT;
    end else if (upd_en) begin
      if (up_hit) begin
        ctr_d[up_idx] = ctr_next(ctr_q[up_idx], upd_taken);
        if (upd_taken) tgt_d[up_idx] = upd_target;
      end else if (upd_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = upd_target;
        ctr_d[up_idx]   = CTR_WEAK_T;
      end
    end
  end

  // Valid bits and counters are the only state that needs a defined reset value
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    ctr_q   <= ctr_d;
  end

  // Tags and targets are qualified by valid and carry no reset
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC selection and BTB-based prediction.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                 XLEN        = 32,
  parameter int                 VPC_BITS    = 32,
  parameter int                 BTB_ENTRIES = BTB_ENTRIES_DEFAULT,
  parameter logic [VPC_BITS-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_D,
  input  logic                MEM_stall,
  input  logic                EX_taken,
  input  logic [VPC_BITS-1:0] EX_redirect_pc,
  input  logic                EX_is_branch,
  input  logic [VPC_BITS-1:0] EX_pc,
  input  logic                EX_br_taken,
  input  logic [VPC_BITS-1:0] EX_br_target,
  fetch_stage_if.master       imem,
  output logic [VPC_BITS-1:0] F_pc,
  output logic [XLEN-1:0]     F_inst,
  output logic                F_BP_taken,
  output logic [VPC_BITS-1:0] F_BP_target_pc
);

  logic [VPC_BITS-1:0] pc_q, pc_d;
  logic [VPC_BITS-1:0] pc_plus4;
  logic                btb_hit, btb_taken;
  logic [VPC_BITS-1:0] btb_target;
  logic                fetch_ok;
  logic                hold;

  btb_2bit #(
    .VPC_BITS    (VPC_BITS),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .lookup_hit    (btb_hit),
    .lookup_taken  (btb_taken),
    .lookup_target (btb_target),
    .upd_en        (EX_is_branch),
    .upd_pc        (EX_pc),
    .upd_taken     (EX_br_taken),
    .upd_target    (EX_br_target)
  );

  assign imem.imem_addr = pc_q;
  assign F_pc           = pc_q;

  // Fetch outputs and next-PC mux; redirect wins over every stall source
  always_comb begin
    pc_plus4       = pc_q + VPC_BITS'(4);
    fetch_ok       = imem.imem_ready && !EX_taken && !rst;
    hold           = stall_D || MEM_stall || !imem.imem_ready;
    F_inst         = fetch_ok ? imem.imem_rdata : XLEN'(NOP_INST);
    F_BP_taken     = fetch_ok && btb_hit && btb_taken;
    F_BP_target_pc = F_BP_taken ? btb_target : pc_plus4;
    if (rst)             pc_d = RESET_PC;
    else if (EX_taken)   pc_d = EX_redirect_pc;
    else if (hold)       pc_d = pc_q;
    else if (F_BP_taken) pc_d = btb_target;
    else                 pc_d = pc_plus4;
  end

  // PC register
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int XLEN = 32;
  localparam int VPC  = 32;

  logic           clk = 1'b0;
  logic           rst, stall_D, MEM_stall, EX_taken, EX_is_branch, EX_br_taken;
  logic [VPC-1:0] EX_redirect_pc, EX_pc, EX_br_target;
  logic [VPC-1:0] F_pc, F_BP_target_pc;
  logic [XLEN-1:0] F_inst;
  logic           F_BP_taken;

  int n_cmp = 0;
  int n_err = 0;

  fetch_stage_if #(.XLEN(XLEN), .VPC_BITS(VPC)) imem_bus ();

  // Memory returns a word derived from the address so fetched data is traceable
  assign imem_bus.imem_rdata = 32'hC000_0000 | imem_bus.imem_addr;

  fetch_stage #(
    .XLEN        (XLEN),
    .VPC_BITS    (VPC),
    .BTB_ENTRIES (16),
    .RESET_PC    (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_D        (stall_D),
    .MEM_stall      (MEM_stall),
    .EX_taken       (EX_taken),
    .EX_redirect_pc (EX_redirect_pc),
    .EX_is_branch   (EX_is_branch),
    .EX_pc          (EX_pc),
    .EX_br_taken    (EX_br_taken),
    .EX_br_target   (EX_br_target),
    .imem           (imem_bus),
    .F_pc           (F_pc),
    .F_inst         (F_inst),
    .F_BP_taken     (F_BP_taken),
    .F_BP_target_pc (F_BP_target_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [VPC-1:0] addr);
    EX_taken = 1'b1;
    EX_redirect_pc = addr;
    tick();
    EX_taken = 1'b0;
    #1;
  endtask

  task automatic train(input logic [VPC-1:0] pc, input logic taken, input logic [VPC-1:0] tgt);
    EX_is_branch = 1'b1;
    EX_pc = pc;
    EX_br_taken = taken;
    EX_br_target = tgt;
    tick();
    EX_is_branch = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; stall_D = 1'b0; MEM_stall = 1'b0; EX_taken = 1'b0;
    EX_is_branch = 1'b0; EX_br_taken = 1'b0;
    EX_redirect_pc = '0; EX_pc = '0; EX_br_target = '0;
    imem_bus.imem_ready = 1'b1;
    #1;
    check_eq("rst_inst", F_inst, 32'h2000_0000);
    check_eq("rst_bp", F_BP_taken, 0);
    tick(); tick();
    check_eq("rst_pc", F_pc, 0);
    rst = 1'b0;
    #1;

    // Sequential fetch
    for (int i = 0; i < 4; i++) begin
      check_eq("seq_pc", F_pc, 32'(4 * i));
      check_eq("seq_bp", F_BP_taken, 0);
      tick();
    end
    check_eq("seq_inst", F_inst, 32'hC000_0010);

    // Decode stall then memory stall
    stall_D = 1'b1;
    tick(); check_eq("stallD_pc1", F_pc, 32'h10);
    tick(); check_eq("stallD_pc2", F_pc, 32'h10);
    stall_D = 1'b0;
    tick(); check_eq("stallD_rel", F_pc, 32'h14);
    MEM_stall = 1'b1;
    tick(); check_eq("memst_pc1", F_pc, 32'h14);
    tick(); check_eq("memst_pc2", F_pc, 32'h14);
    MEM_stall = 1'b0;
    tick(); check_eq("memst_rel", F_pc, 32'h18);

    // I-cache miss at 0x20
    redirect(32'h20);
    check_eq("miss_start", F_pc, 32'h20);
    imem_bus.imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("miss_inst", F_inst, 32'h2000_0000);
      tick();
      check_eq("miss_pc", F_pc, 32'h20);
    end
    imem_bus.imem_ready = 1'b1;
    #1;
    check_eq("miss_rel_inst", F_inst, 32'hC000_0020);
    tick(); check_eq("miss_rel_pc", F_pc, 32'h24);

    // Redirect beats a decode stall
    EX_taken = 1'b1; EX_redirect_pc = 32'h200; stall_D = 1'b1;
    #1;
    check_eq("redir_inst", F_inst, 32'h2000_0000);
    check_eq("redir_bp", F_BP_taken, 0);
    tick();
    EX_taken = 1'b0; stall_D = 1'b0;
    #1;
    check_eq("redir_pc", F_pc, 32'h200);

    // Train 0x40 taken -> predicted; same-cycle not-taken update must not affect lookup
    train(32'h40, 1'b1, 32'h100);
    redirect(32'h40);
    EX_is_branch = 1'b1; EX_pc = 32'h40; EX_br_taken = 1'b0; EX_br_target = 32'h0;
    #1;
    check_eq("bp_taken", F_BP_taken, 1);
    check_eq("bp_target", F_BP_target_pc, 32'h100);
    check_eq("bp_inst", F_inst, 32'hC000_0040);
    tick();
    EX_is_branch = 1'b0;
    #1;
    check_eq("bp_next_pc", F_pc, 32'h100);

    // Second not-taken: counter 0
    train(32'h40, 1'b0, 32'h0);
    redirect(32'h40);
    check_eq("nt_bp", F_BP_taken, 0);
    check_eq("nt_target", F_BP_target_pc, 32'h44);
    tick(); check_eq("nt_next_pc", F_pc, 32'h44);

    // Saturate at 0, then one taken gives weak-not-taken only
    train(32'h40, 1'b0, 32'h0);
    train(32'h40, 1'b1, 32'h100);
    redirect(32'h40);
    check_eq("sat0_bp", F_BP_taken, 0);
    // Second taken crosses to predicted and rewrites the target
    train(32'h40, 1'b1, 32'h140);
    redirect(32'h40);
    check_eq("retrain_bp", F_BP_taken, 1);
    check_eq("retrain_tgt", F_BP_target_pc, 32'h140);

    // Alias 0x80 replaces 0x40 in index 0
    train(32'h80, 1'b1, 32'h300);
    redirect(32'h40);
    check_eq("alias_old_bp", F_BP_taken, 0);
    check_eq("alias_old_tgt", F_BP_target_pc, 32'h44);
    redirect(32'h80);
    check_eq("alias_new_bp", F_BP_taken, 1);
    check_eq("alias_new_tgt", F_BP_target_pc, 32'h300);
    tick(); check_eq("alias_next_pc", F_pc, 32'h300);

    // PC+4 wraps modulo 2^32
    redirect(32'hFFFF_FFFC);
    tick(); check_eq("wrap_pc", F_pc, 32'h0);

    // Reset beats redirect and clears the BTB
    rst = 1'b1; EX_taken = 1'b1; EX_redirect_pc = 32'h80;
    tick();
    rst = 1'b0; EX_taken = 1'b0;
    #1;
    check_eq("rst_prio_pc", F_pc, 32'h0);
    redirect(32'h80);
    check_eq("rst_btb_bp", F_BP_taken, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
